// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: FSM states and op codes.
// The main decoder and ALU decoder import the same op encodings.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } md_state_t;

    localparam logic [1:0] MD_MUL = 2'b00;
    localparam logic [1:0] MD_DIV = 2'b01;
    localparam logic [1:0] MD_REM = 2'b10;

endpackage

// File: rtl/muldiv_iter.sv
// One iteration step of the muldiv unit: shift-add (multiply) or
// restore-subtract (divide), selected by div_mode.
module muldiv_iter #(
    parameter int unsigned WIDTH = 19
) (
    input  logic               div_mode,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH:0]     rem,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    output logic [2*WIDTH-1:0] acc_next,
    output logic [WIDTH:0]     rem_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic             fits;

    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opa};
        shifted  = {rem, acc[WIDTH-1]};
        diff     = shifted - {2'b00, opb};
        // No borrow out of the subtract means the divisor fits this step.
        fits     = ~diff[WIDTH+1];
        acc_next = acc;
        rem_next = rem;
        if (div_mode) begin
            rem_next = fits ? diff[WIDTH:0] : shifted[WIDTH:0];
            acc_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], fits};
        end else begin
            // Multiplier sits in the low half and drains LSB-first as the product grows in.
            acc_next = acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned MUL/DIV/REM unit, one bit per cycle, start/done handshake.
// Optional product-overflow flag output enabled by defining MULDIV_OVF_EN.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
`ifdef MULDIV_OVF_EN
    ,
    output logic             mul_ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    md_state_t          state;
    logic [CW-1:0]      cnt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     rem_next;

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .div_mode(state == DIV),
        .acc     (acc),
        .rem     (rem),
        .opa     (opa),
        .opb     (opb),
        .acc_next(acc_next),
        .rem_next(rem_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            op_q        <= '0;
            opa         <= '0;
            opb         <= '0;
            acc         <= '0;
            rem         <= '0;
`ifdef MULDIV_OVF_EN
            mul_ovf     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        op_q <= op;
                        opa  <= a;
                        opb  <= b;
                        cnt  <= CW'(WIDTH);
                        rem  <= '0;
                        case (op)
                            MD_MUL: begin
                                state <= MUL;
                                busy  <= 1'b1;
                                acc   <= {{WIDTH{1'b0}}, b};
                            end
                            MD_DIV, MD_REM: begin
                                if (b == '0) begin
                                    state       <= DONE;
                                    done        <= 1'b1;
                                    result      <= (op == MD_DIV) ? '1 : a;
                                    div_by_zero <= 1'b1;
`ifdef MULDIV_OVF_EN
                                    mul_ovf     <= 1'b0;
`endif
                                end else begin
                                    state <= DIV;
                                    busy  <= 1'b1;
                                    acc   <= {{WIDTH{1'b0}}, a};
                                end
                            end
                            default: begin
                                state       <= DONE;
                                done        <= 1'b1;
                                result      <= '0;
                                div_by_zero <= 1'b0;
`ifdef MULDIV_OVF_EN
                                mul_ovf     <= 1'b0;
`endif
                            end
                        endcase
                    end
                end
                MUL, DIV: begin
                    acc <= acc_next;
                    rem <= rem_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        div_by_zero <= 1'b0;
                        result      <= (state == DIV && op_q == MD_REM) ? rem_next[WIDTH-1:0]
                                                                        : acc_next[WIDTH-1:0];
`ifdef MULDIV_OVF_EN
                        mul_ovf     <= (state == MUL) && (acc_next[2*WIDTH-1:WIDTH] != '0);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
